// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: word width, data word and FSM state.
package fifo_arb_pkg;

  localparam int unsigned DATA_W = 24;

  typedef enum logic {IDLE, BURST} arb_state_t;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter, grouped as one bundle.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import fifo_arb_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  word_t [NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      full;
  logic                      w_enable;
  word_t                     w_data;
  logic [IdxW-1:0]           grant_id;
  logic                      busy;
  logic [31:0]               words_written;

  modport master (
    input  req_valid, req_last, req_data, full,
    output req_ready, w_enable, w_data, grant_id, busy, words_written
  );

  modport slave (
    output req_valid, req_last, req_data, full,
    input  req_ready, w_enable, w_data, grant_id, busy, words_written
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from ptr_i+1.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    // k = NUM_REQ wraps back to ptr_i itself, so the last owner is considered last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  fifo_wr_arbiter_if.master    bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t          state_q;
  logic [IdxW-1:0]     grant_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [7:0]          beat_cnt_q;
  logic [3:0]          idle_cnt_q;
  logic [31:0]         words_q;

  logic [IdxW-1:0]     winner;
  logic                any_req;
  logic                in_burst;
  logic                gnt_valid;
  logic                gnt_last;
  logic                xfer;
  logic                idle_tick;
  logic                release_burst;
  logic [NUM_REQ-1:0]  ready;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (winner),
    .any_o (any_req)
  );

  assign in_burst  = (state_q == BURST);
  assign gnt_valid = bus.req_valid[grant_q];
  assign gnt_last  = bus.req_last[grant_q];
  assign xfer      = in_burst & gnt_valid & ~bus.full;
  // Full stalls neither count as idle nor release the grant.
  assign idle_tick = in_burst & ~gnt_valid & ~bus.full;

  assign release_burst = (xfer && (gnt_last || beat_cnt_q == 8'(MAX_BURST - 1))) ||
                         (idle_tick && idle_cnt_q == 4'(IDLE_TIMEOUT - 1));

  always_comb begin
    ready = '0;
    if (in_burst && !bus.full) begin
      ready[grant_q] = 1'b1;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.w_enable      = xfer;
  assign bus.w_data        = xfer ? bus.req_data[grant_q] : '0;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = in_burst;
  assign bus.words_written = words_q;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IdxW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      words_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= winner;
            state_q    <= BURST;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
          end
        end
        BURST: begin
          if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            words_q    <= words_q + 32'd1;
            idle_cnt_q <= '0;
          end else if (idle_tick) begin
            idle_cnt_q <= idle_cnt_q + 4'd1;
          end
          if (release_burst) begin
            state_q  <= IDLE;
            rr_ptr_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
